audio_decimator: RTL

//  Consumes the free-running 10-bit unsigned L/R delta-sigma ADC words and produces a

---
 rtl/audio_decimator.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/audio_decimator.sv
// L/R delta-sigma ADC decimator: centres the 10-bit words, mixes per mode,
// boxcar-averages DECIM captures, applies a gain shift and saturates to OUT_W.
module audio_decimator #(
    parameter int SAMPLE_DIV = 256,
    parameter int LOG2_DECIM = 4,
    parameter int GAIN_SH    = 2,
    parameter int OUT_W      = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [9:0]              i_adcdt_l,
    input  logic [9:0]              i_adcdt_r,
    input  logic [1:0]              i_mode,
    input  logic                    i_clr_clip,
    output logic signed [OUT_W-1:0] o_sample,
    output logic                    o_valid,
    output logic                    o_clip
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int ACC_W = 12 + LOG2_DECIM;
    localparam int SH_W  = ACC_W + GAIN_SH;
    localparam int EXT_W = (SH_W > OUT_W) ? SH_W : OUT_W;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = -SAT_MAX - EXT_W'(1);

    function automatic logic signed [EXT_W-1:0] scale(input logic signed [ACC_W-1:0] s);
        return EXT_W'(s) <<< GAIN_SH;
    endfunction

    function automatic logic is_sat(input logic signed [EXT_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [EXT_W-1:0] v);
        if (v > SAT_MAX)
            return $signed(SAT_MAX[OUT_W-1:0]);
        else if (v < SAT_MIN)
            return $signed(SAT_MIN[OUT_W-1:0]);
        else
            return $signed(v[OUT_W-1:0]);
    endfunction

    logic [DIV_W-1:0]       div_cnt;
    logic                   tick;
    logic signed [10:0]     s_l_p0;
    logic signed [10:0]     s_r_p0;
    logic                   vld_p0;
    logic signed [11:0]     mix;
    logic signed [ACC_W-1:0] acc_p1;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] sum_p1;
    logic [LOG2_DECIM-1:0]  dec_cnt;
    logic [1:0]             mode_lat;
    logic                   vld_p1;
    logic signed [EXT_W-1:0] scaled;

    assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    // Stage 1: capture and re-centre ADC words on tick
    always_ff @(posedge i_clk) begin
        if (tick) begin
            s_l_p0 <= $signed({1'b0, i_adcdt_l}) - 11'sd512;
            s_r_p0 <= $signed({1'b0, i_adcdt_r}) - 11'sd512;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= tick;
    end

    // Stage 2: mix per block-latched mode and accumulate DECIM captures
    always_comb begin
        mix = '0;
        case (mode_lat)
            2'b00:   mix = $signed({s_l_p0[10], s_l_p0}) + $signed({s_r_p0[10], s_r_p0});
            2'b01:   mix = $signed({s_l_p0, 1'b0});
            2'b10:   mix = $signed({s_r_p0, 1'b0});
            default: mix = '0;
        endcase
    end

    assign acc_next = acc_p1 + ACC_W'(mix);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_p1   <= '0;
            sum_p1   <= '0;
            dec_cnt  <= '0;
            mode_lat <= 2'b00;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (vld_p0) begin
                if (&dec_cnt) begin
                    sum_p1   <= acc_next;
                    acc_p1   <= '0;
                    dec_cnt  <= '0;
                    vld_p1   <= 1'b1;
                    mode_lat <= i_mode;
                end else begin
                    acc_p1  <= acc_next;
                    dec_cnt <= dec_cnt + 1'b1;
                end
            end
        end
    end

    // Stage 3: gain shift, saturate, register output and sticky clip flag
    assign scaled = scale(sum_p1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sample <= '0;
            o_valid  <= 1'b0;
            o_clip   <= 1'b0;
        end else begin
            o_valid <= vld_p1;
            if (vld_p1)
                o_sample <= saturate(scaled);
            if (vld_p1 && is_sat(scaled))
                o_clip <= 1'b1;
            else if (i_clr_clip)
                o_clip <= 1'b0;
        end
    end

endmodule
